i2s_tx_sequencer: RTL and testbench

//  Master-side timing and sample sequencer for the I2S transmit shifter.

---
 rtl/i2s_tx_sequencer_if.sv | 25 ++
 rtl/i2s_tx_sequencer.sv | 130 +++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_sequencer_if.sv
// Upstream sample-pair handshake between a sample source and the I2S
// transmit sequencer. A pair moves in any ck where in_valid and in_ready
// are both high.
interface i2s_tx_sequencer_if;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        in_valid;
    logic        in_ready;

    // Sample source side
    modport master (
        output in_l,
        output in_r,
        output in_valid,
        input  in_ready
    );

    // Sequencer side
    modport slave (
        input  in_l,
        input  in_r,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit timing and sample sequencer.
//
// Divides i_ck into the bit clock (o_sck) and word select (o_ws). It pulls
// one stereo pair per frame from the upstream handshake and presents it on
// o_data_l/o_data_r. The pair is refreshed mid right slot, so the words are
// stable whenever the shifter loads them.
//
// Build option: I2S_SEQ_HOLD_EN
//   defined     - on underrun the previous pair is kept (last sample repeats)
//   not defined - on underrun both words are loaded with zero (mute)
//
// Parameters:
//   DIVIDE    ck cycles per sck half-period (>= 1)
//   SLOT_BITS sck cycles per channel slot (>= 16, even)
//
// Every output comes straight from a flop, so no input has a combinational
// path to an output. in_ready is registered as a one-ck window, and the
// transfer takes place on the ck edge that closes that window.
module i2s_tx_sequencer #(
    parameter int DIVIDE    = 8,
    parameter int SLOT_BITS = 16
) (
    input  logic                 i_ck,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    i2s_tx_sequencer_if.slave    src,
    output logic                 o_sck,
    output logic                 o_ws,
    output logic [15:0]          o_data_l,
    output logic [15:0]          o_data_r,
    output logic                 o_frame,
    output logic                 o_underrun
);

    // Counter widths. The prescaler keeps at least one bit, even for DIVIDE=1.
    localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIVIDE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] BIT_SLOT   = BW'(SLOT_BITS);
    localparam logic [BW-1:0] BIT_UPDATE = BW'(SLOT_BITS + SLOT_BITS / 2);

    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_bit;
    logic          r_sck;
    logic          r_ws;
    logic          r_frame;
    logic          r_in_ready;
    logic          r_underrun;
    logic [15:0]   r_data_l;
    logic [15:0]   r_data_r;

    logic          w_tick;
    logic          w_fall;
    logic          w_wrap;
    logic [BW-1:0] w_bit_next;
    logic          w_take;
    logic          w_starve;

    // Prescaler terminal count. Combined with sck high, it marks the falling edge.
    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_fall     = w_tick & r_sck;
    assign w_wrap     = (r_bit == BIT_LAST);
    assign w_bit_next = w_wrap ? '0 : (r_bit + 1'b1);

    // The handshake closes on the edge after the in_ready window. Dropping en
    // in that window cancels it: neither a load nor an underrun happens.
    assign w_take   = i_en & r_in_ready & src.in_valid;
    assign w_starve = i_en & r_in_ready & ~src.in_valid;

    // Timing chain: prescaler, bit clock, bit counter and the strobes derived from them.
    always_ff @(posedge i_ck) begin
        if (!i_rst_n || !i_en) begin
            r_presc    <= '0;
            r_bit      <= '0;
            r_sck      <= 1'b0;
            r_ws       <= 1'b0;
            r_frame    <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_frame    <= 1'b0;
            r_in_ready <= 1'b0;
            if (w_tick) begin
                r_presc <= '0;
                r_sck   <= ~r_sck;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_fall) begin
                r_bit      <= w_bit_next;
                r_ws       <= (w_bit_next >= BIT_SLOT);
                r_frame    <= w_wrap;
                r_in_ready <= (w_bit_next == BIT_UPDATE);
            end
        end
    end

    // Sample pair registers and the underrun strobe. The pair is held while en is low.
    always_ff @(posedge i_ck) begin
        if (!i_rst_n) begin
            r_data_l   <= '0;
            r_data_r   <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_starve;
            if (w_take) begin
                r_data_l <= src.in_l;
                r_data_r <= src.in_r;
            end else if (w_starve) begin
`ifdef I2S_SEQ_HOLD_EN
                r_data_l <= r_data_l;
                r_data_r <= r_data_r;
`else
                r_data_l <= '0;
                r_data_r <= '0;
`endif
            end
        end
    end

    assign src.in_ready = r_in_ready;
    assign o_sck        = r_sck;
    assign o_ws         = r_ws;
    assign o_frame      = r_frame;
    assign o_underrun   = r_underrun;
    assign o_data_l     = r_data_l;
    assign o_data_r     = r_data_r;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer. Two instances share one stimulus stream:
// one with DIVIDE=4 and one with DIVIDE=1, both with SLOT_BITS=16. After
// every ck edge the bench compares each output with a reference model.
// The model works out the timing from the number of enabled edges since
// the last restart.
module tb_i2s_tx_sequencer;

    localparam int SB     = 16;
    localparam int DIV_A  = 4;
    localparam int DIV_B  = 1;
    localparam int N_CYC  = 7000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] s_l;
    logic [15:0] s_r;
    logic        s_valid;

    always #5 clk = ~clk;

    i2s_tx_sequencer_if if_a ();
    i2s_tx_sequencer_if if_b ();

    assign if_a.in_l     = s_l;
    assign if_a.in_r     = s_r;
    assign if_a.in_valid = s_valid;
    assign if_b.in_l     = s_l;
    assign if_b.in_r     = s_r;
    assign if_b.in_valid = s_valid;

    logic        a_sck, a_ws, a_frame, a_underrun;
    logic [15:0] a_dl, a_dr;
    logic        b_sck, b_ws, b_frame, b_underrun;
    logic [15:0] b_dl, b_dr;

    i2s_tx_sequencer #(.DIVIDE(DIV_A), .SLOT_BITS(SB)) dut_a (
        .i_ck       (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .src        (if_a.slave),
        .o_sck      (a_sck),
        .o_ws       (a_ws),
        .o_data_l   (a_dl),
        .o_data_r   (a_dr),
        .o_frame    (a_frame),
        .o_underrun (a_underrun)
    );

    i2s_tx_sequencer #(.DIVIDE(DIV_B), .SLOT_BITS(SB)) dut_b (
        .i_ck       (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .src        (if_b.slave),
        .o_sck      (b_sck),
        .o_ws       (b_ws),
        .o_data_l   (b_dl),
        .o_data_r   (b_dr),
        .o_frame    (b_frame),
        .o_underrun (b_underrun)
    );

    typedef struct {
        int          t;       // enabled edges since the last restart
        bit          sck;
        bit          ws;
        bit          frame;
        bit          ready;
        bit          underrun;
        logic [15:0] dl;
        logic [15:0] dr;
    } mdl_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_g = 0;

    mdl_t ma;
    mdl_t mb;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc_g, obs, exp);
        end
    endtask

    // State after one ck edge. sck is high in odd DIVIDE-long stretches, a
    // fall happens every 2*DIVIDE edges, and the bit index is the fall count
    // modulo the frame length.
    function automatic mdl_t model_step(input mdl_t s, input int d, input bit rst_i,
                                        input bit en_i, input bit valid_i,
                                        input logic [15:0] l_i, input logic [15:0] r_i);
        mdl_t n;
        int   f;
        n          = s;
        n.sck      = 1'b0;
        n.ws       = 1'b0;
        n.frame    = 1'b0;
        n.ready    = 1'b0;
        n.underrun = 1'b0;
        if (!rst_i) begin
            n.t  = 0;
            n.dl = '0;
            n.dr = '0;
        end else if (!en_i) begin
            n.t = 0;
        end else begin
            if (s.ready) begin
                if (valid_i) begin
                    n.dl = l_i;
                    n.dr = r_i;
                end else begin
                    n.underrun = 1'b1;
`ifndef I2S_SEQ_HOLD_EN
                    n.dl = '0;
                    n.dr = '0;
`endif
                end
            end
            n.t   = s.t + 1;
            f     = n.t / (2 * d);
            n.sck = ((n.t / d) % 2) == 1;
            n.ws  = (f % (2 * SB)) >= SB;
            if ((n.t % (2 * d)) == 0) begin
                n.frame = (f % (2 * SB)) == 0;
                n.ready = (f % (2 * SB)) == (SB + SB / 2);
            end
        end
        return n;
    endfunction

    task automatic compare_all(input string id, input mdl_t m,
                               input logic sck, input logic ws, input logic frame,
                               input logic ready, input logic und,
                               input logic [15:0] dl, input logic [15:0] dr);
        check_val({id, ".sck"},      32'(sck),   32'(m.sck));
        check_val({id, ".ws"},       32'(ws),    32'(m.ws));
        check_val({id, ".frame"},    32'(frame), 32'(m.frame));
        check_val({id, ".in_ready"}, 32'(ready), 32'(m.ready));
        check_val({id, ".underrun"}, 32'(und),   32'(m.underrun));
        check_val({id, ".data_l"},   32'(dl),    32'(m.dl));
        check_val({id, ".data_r"},   32'(dr),    32'(m.dr));
    endtask

    initial begin
        int en_off;
        int rst_cnt;
        rst_n   = 1'b0;
        en      = 1'b1;
        s_l     = '0;
        s_r     = '0;
        s_valid = 1'b0;
        en_off  = 0;
        rst_cnt = 0;
        ma.t = 0; ma.sck = 0; ma.ws = 0; ma.frame = 0; ma.ready = 0; ma.underrun = 0;
        ma.dl = '0; ma.dr = '0;
        mb = ma;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            cyc_g = cyc;
            if (cyc < 3) begin
                // Reset held with en high
                rst_n = 1'b0; en = 1'b1; s_valid = 1'b1; s_l = 16'h1234; s_r = 16'hABCD;
            end else if (cyc < 3 + 512) begin
                rst_n = 1'b1; en = 1'b1; s_valid = 1'b1; s_l = 16'h1234; s_r = 16'hABCD;
            end else if (cyc < 3 + 768) begin
                s_valid = 1'b1; s_l = 16'h1111; s_r = 16'h2222;
            end else if (cyc < 3 + 1024) begin
                // Source starved for a whole frame
                s_valid = 1'b0; s_l = 16'h5A5A; s_r = 16'hA5A5;
            end else if (cyc < 3 + 1024 + 83) begin
                s_valid = 1'b1; s_l = 16'h0F0F; s_r = 16'hF0F0;
            end else if (cyc < 3 + 1024 + 103) begin
                // en dropped in the middle of bit 10 of the wide divider instance
                en = 1'b0;
            end else if (cyc < 3 + 1024 + 103 + 300) begin
                en = 1'b1;
            end else begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_l     = 16'($urandom);
                s_r     = 16'($urandom);
                if (rst_cnt > 0) begin
                    rst_cnt--;
                    rst_n = (rst_cnt == 0);
                end else if ($urandom_range(0, 1499) == 0) begin
                    rst_cnt = $urandom_range(1, 3);
                    rst_n   = 1'b0;
                end
                if (en_off > 0) begin
                    en_off--;
                    en = (en_off == 0);
                end else if ($urandom_range(0, 399) == 0) begin
                    en_off = $urandom_range(1, 40);
                    en     = 1'b0;
                end
            end

            @(posedge clk);
            ma = model_step(ma, DIV_A, rst_n, en, s_valid, s_l, s_r);
            mb = model_step(mb, DIV_B, rst_n, en, s_valid, s_l, s_r);
            #1;
            compare_all("A", ma, a_sck, a_ws, a_frame, if_a.in_ready, a_underrun, a_dl, a_dr);
            compare_all("B", mb, b_sck, b_ws, b_frame, if_b.in_ready, b_underrun, b_dl, b_dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
